bp_nonsynth_cosim_watchdog: RTL and testbench

Non-synthesizable progress monitor in the cosim clock domain, downstream of the commit-stream cosim checker. It snoops each commit record the checker dequeues (valid/yumi on the commit async-FIFO read side) and tracks retired-instruction and trap counts. It flags hangs (no retirement for a programmable number of cycles) and clean self-loop termination (repeated `jal x0,0`). Testbench top reads its status outputs to end simulation with PASS/HANG.

---
 rtl/bp_nonsynth_cosim_watchdog_pkg.sv | 10 +
 rtl/bp_nonsynth_cosim_pc_history.sv | 37 +++
 rtl/bp_nonsynth_cosim_watchdog.sv | 108 ++++++++++
 tb/tb_bp_nonsynth_cosim_watchdog.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_cosim_watchdog_pkg.sv
// bp_nonsynth_cosim_watchdog_pkg: shared cosim watchdog state enum and the jal x0,0 self-loop encoding
package bp_nonsynth_cosim_watchdog_pkg;
  typedef enum logic [1:0] {
    e_wd_idle = 2'd0,
    e_wd_run  = 2'd1,
    e_wd_done = 2'd2,
    e_wd_hang = 2'd3
  } wd_state_e;
  localparam logic [31:0] self_loop_instr_gp = 32'h0000006f;
endpackage

// File: rtl/bp_nonsynth_cosim_pc_history.sv
// bp_nonsynth_cosim_pc_history: circular pc/instr log dumped oldest-first on dump_i (cosim_clk_i, reset_i async low, w_v_i/pc_i/instr_i write, dump_i print)
module bp_nonsynth_cosim_pc_history
  #(parameter int vaddr_width_p = 39
  , parameter int els_p = 8)
  (input  logic                     cosim_clk_i
  , input  logic                     reset_i
  , input  logic                     w_v_i
  , input  logic [vaddr_width_p-1:0] pc_i
  , input  logic [31:0]              instr_i
  , input  logic                     dump_i
  );
  localparam int ptr_w_lp = $clog2(els_p);
  logic [vaddr_width_p-1:0] pc_mem [els_p];
  logic [31:0] instr_mem [els_p];
  logic [ptr_w_lp-1:0] wptr_r, start;
  logic [ptr_w_lp:0] cnt_r;
  assign start = wptr_r - cnt_r[ptr_w_lp-1:0];
  always_ff @(posedge cosim_clk_i or negedge reset_i)
    if (!reset_i) begin
      wptr_r <= '0;
      cnt_r  <= '0;
    end else if (w_v_i) begin
      wptr_r <= wptr_r + ptr_w_lp'(1);
      cnt_r  <= (cnt_r == (ptr_w_lp+1)'(els_p)) ? cnt_r : cnt_r + (ptr_w_lp+1)'(1);
    end
  always_ff @(posedge cosim_clk_i)
    if (w_v_i) begin
      pc_mem[wptr_r]    <= pc_i;
      instr_mem[wptr_r] <= instr_i;
    end
  always_ff @(posedge cosim_clk_i)
    if (reset_i && dump_i)
      for (int i = 0; i < els_p; i++)
        if (i < int'(cnt_r))
          $display("COSIM_WATCHDOG: hist[%0d] pc=%h instr=%h", i,
                   pc_mem[start + ptr_w_lp'(i)], instr_mem[start + ptr_w_lp'(i)]);
endmodule

// File: rtl/bp_nonsynth_cosim_watchdog.sv
// bp_nonsynth_cosim_watchdog: commit-stream hang/self-loop monitor (cosim_clk_i, reset_i async low; commit snoop + en/freeze/stall_limit in; instr/trap counts, state, sticky hang/done out; pc history dump under BP_COSIM_WATCHDOG_HISTORY_EN)
module bp_nonsynth_cosim_watchdog
  import bp_nonsynth_cosim_watchdog_pkg::*;
  #(parameter int vaddr_width_p = 39
  , parameter int spin_limit_p = 4
  , parameter int stall_width_p = 32
  , parameter int history_els_p = 8)
  (input  logic                     cosim_clk_i
  , input  logic                     reset_i
  , input  logic                     en_i
  , input  logic                     freeze_i
  , input  logic                     commit_v_i
  , input  logic                     commit_yumi_i
  , input  logic                     instret_v_i
  , input  logic                     trap_v_i
  , input  logic                     debug_i
  , input  logic [vaddr_width_p-1:0] commit_pc_i
  , input  logic [31:0]              commit_instr_i
  , input  logic [stall_width_p-1:0] stall_limit_i
  , output logic [63:0]              instr_cnt_o
  , output logic [31:0]              trap_cnt_o
  , output logic [1:0]               state_o
  , output logic                     hang_o
  , output logic                     done_o
  );
  localparam int spin_w_lp = $clog2(spin_limit_p + 1);
  wd_state_e state_r, state_n;
  logic [63:0] instr_cnt_r, instr_cnt_n;
  logic [31:0] trap_cnt_r, trap_cnt_n;
  logic [stall_width_p-1:0] stall_r, stall_n;
  logic [spin_w_lp-1:0] spin_r, spin_n;
  logic [vaddr_width_p-1:0] last_pc_r;
  logic hang_r, done_r;
  logic run, accept, retire, trap, progress, spin_trig, spin_hit, hang_hit, clr;
  always_comb begin
    run         = state_r == e_wd_run;
    accept      = commit_v_i & commit_yumi_i;
    retire      = accept & instret_v_i & ~debug_i;
    trap        = accept & trap_v_i;
    progress    = accept & (instret_v_i | trap_v_i);
    spin_trig   = retire & (commit_instr_i == self_loop_instr_gp) & (commit_pc_i == last_pc_r);
    instr_cnt_n = (retire & !(&instr_cnt_r)) ? instr_cnt_r + 64'd1 : instr_cnt_r;
    trap_cnt_n  = (trap & !(&trap_cnt_r)) ? trap_cnt_r + 32'd1 : trap_cnt_r;
    stall_n     = progress ? '0 : (&stall_r) ? stall_r : stall_r + stall_width_p'(1);
    spin_n      = trap ? '0 : spin_trig ? spin_r + spin_w_lp'(1) : retire ? '0 : spin_r;
    spin_hit    = spin_n == spin_w_lp'(spin_limit_p - 1);
    hang_hit    = (stall_limit_i != '0) & (stall_n == stall_limit_i);
    clr         = (state_r == e_wd_idle) | (run & freeze_i);
    state_n     = (state_r == e_wd_idle) ? ((en_i & ~freeze_i) ? e_wd_run : e_wd_idle)
                : !run     ? state_r
                : freeze_i ? e_wd_idle
                : spin_hit ? e_wd_done
                : hang_hit ? e_wd_hang
                : e_wd_run;
  end
  always_ff @(posedge cosim_clk_i or negedge reset_i)
    if (!reset_i) begin
      state_r     <= e_wd_idle;
      instr_cnt_r <= '0;
      trap_cnt_r  <= '0;
      stall_r     <= '0;
      spin_r      <= '0;
      last_pc_r   <= '0;
      hang_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      hang_r  <= hang_r | (run & (state_n == e_wd_hang));
      done_r  <= done_r | (run & (state_n == e_wd_done));
      if (clr) begin
        instr_cnt_r <= '0;
        trap_cnt_r  <= '0;
        stall_r     <= '0;
        spin_r      <= '0;
      end else if (run) begin
        instr_cnt_r <= instr_cnt_n;
        trap_cnt_r  <= trap_cnt_n;
        stall_r     <= stall_n;
        spin_r      <= spin_n;
        if (retire) last_pc_r <= commit_pc_i;
      end
    end
  always_ff @(posedge cosim_clk_i)
    if (reset_i && run && !freeze_i)
      if (state_n == e_wd_done) $display("COSIM_WATCHDOG: DONE instr_cnt=%0d", instr_cnt_n);
      else if (state_n == e_wd_hang) $display("COSIM_WATCHDOG: HANG instr_cnt=%0d", instr_cnt_n);
  // The history depth must be a power of two so the write pointer wraps naturally.
  if ((history_els_p & (history_els_p - 1)) != 0) begin : history_els_not_pow2
  end
`ifdef BP_COSIM_WATCHDOG_HISTORY_EN
  bp_nonsynth_cosim_pc_history
    #(.vaddr_width_p(vaddr_width_p), .els_p(history_els_p))
    history
      (.cosim_clk_i(cosim_clk_i)
      ,.reset_i(reset_i)
      ,.w_v_i(run & accept)
      ,.pc_i(commit_pc_i)
      ,.instr_i(commit_instr_i)
      ,.dump_i(run & (state_n == e_wd_hang))
      );
`else
`endif
  assign instr_cnt_o = instr_cnt_r;
  assign trap_cnt_o  = trap_cnt_r;
  assign state_o     = state_r;
  assign hang_o      = hang_r;
  assign done_o      = done_r;
endmodule

// File: tb/tb_bp_nonsynth_cosim_watchdog.sv
// tb_bp_nonsynth_cosim_watchdog: directed and random checks of the cosim watchdog against a behavioural model
module tb_bp_nonsynth_cosim_watchdog;
  localparam int vw = 39;
  localparam int spin_lim = 4;
  localparam int sw = 32;
  localparam logic [31:0] jal_self = 32'h0000006f;
  localparam logic [vw-1:0] loop_pc = 39'h80000100;
  logic cosim_clk_i = 1'b0;
  logic reset_i, en_i, freeze_i, commit_v_i, commit_yumi_i, instret_v_i, trap_v_i, debug_i;
  logic [vw-1:0] commit_pc_i;
  logic [31:0] commit_instr_i;
  logic [sw-1:0] stall_limit_i;
  logic [63:0] instr_cnt_o;
  logic [31:0] trap_cnt_o;
  logic [1:0] state_o;
  logic hang_o, done_o;
  int total = 0;
  int bad = 0;
  int m_state;
  longint unsigned m_instr, m_idle;
  int unsigned m_trap;
  int m_streak;
  logic [vw-1:0] m_last;
  bit m_hang, m_done;
  bp_nonsynth_cosim_watchdog #(.vaddr_width_p(vw), .spin_limit_p(spin_lim), .stall_width_p(sw), .history_els_p(8)) dut
    (.cosim_clk_i(cosim_clk_i), .reset_i(reset_i), .en_i(en_i), .freeze_i(freeze_i)
    ,.commit_v_i(commit_v_i), .commit_yumi_i(commit_yumi_i), .instret_v_i(instret_v_i)
    ,.trap_v_i(trap_v_i), .debug_i(debug_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i)
    ,.stall_limit_i(stall_limit_i), .instr_cnt_o(instr_cnt_o), .trap_cnt_o(trap_cnt_o)
    ,.state_o(state_o), .hang_o(hang_o), .done_o(done_o));
  always #5 cosim_clk_i = ~cosim_clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "/state"}, 64'(state_o), 64'(m_state));
    chk({tag, "/instr"}, instr_cnt_o, m_instr);
    chk({tag, "/trap"}, 64'(trap_cnt_o), 64'(m_trap));
    chk({tag, "/hang"}, 64'(hang_o), 64'(m_hang));
    chk({tag, "/done"}, 64'(done_o), 64'(m_done));
  endtask
  // Behavioural model: applies the spec's per-cycle rules to the inputs about to be clocked.
  task automatic model_step();
    bit acc, ret, trp;
    acc = commit_v_i && commit_yumi_i;
    ret = acc && instret_v_i && !debug_i;
    trp = acc && trap_v_i;
    if (m_state == 0) begin
      if (en_i && !freeze_i) m_state = 1;
    end else if (m_state == 1) begin
      if (freeze_i) begin
        m_state = 0; m_instr = 0; m_trap = 0; m_idle = 0; m_streak = 0;
      end else begin
        if (ret) m_instr++;
        if (trp) m_trap++;
        m_idle = (acc && (instret_v_i || trap_v_i)) ? 0 : m_idle + 1;
        if (trp) m_streak = 0;
        else if (ret) m_streak = (commit_instr_i == jal_self && commit_pc_i == m_last) ? m_streak + 1 : 0;
        if (ret) m_last = commit_pc_i;
        if (m_streak == spin_lim - 1) begin m_state = 2; m_done = 1; end
        else if (stall_limit_i != 0 && m_idle == 64'(stall_limit_i)) begin m_state = 3; m_hang = 1; end
      end
    end
  endtask
  // f = {valid, yumi, instret, trap, debug}
  task automatic cyc(input string tag, input logic [4:0] f, input logic [vw-1:0] pc, input logic [31:0] ins);
    {commit_v_i, commit_yumi_i, instret_v_i, trap_v_i, debug_i} = f;
    commit_pc_i = pc;
    commit_instr_i = ins;
    model_step();
    @(posedge cosim_clk_i);
    #1;
    check_all(tag);
  endtask
  task automatic do_reset();
    reset_i = 1'b0; en_i = 1'b0; freeze_i = 1'b0;
    {commit_v_i, commit_yumi_i, instret_v_i, trap_v_i, debug_i} = '0;
    commit_pc_i = '0; commit_instr_i = '0;
    m_state = 0; m_instr = 0; m_idle = 0; m_trap = 0; m_streak = 0; m_last = '0; m_hang = 0; m_done = 0;
    #2;
    check_all("reset");
    @(posedge cosim_clk_i);
    #1;
    reset_i = 1'b1;
  endtask
  initial begin
    stall_limit_i = '0;
    do_reset();
    chk("reset_state", 64'(state_o), 64'd0);
    chk("reset_instr", instr_cnt_o, 64'd0);
    en_i = 1'b1;
    cyc("t1_enter", 5'b00000, '0, '0);
    for (int i = 0; i < 10; i++) cyc("t1_ret", 5'b11100, 39'h1000 + 39'(4 * i), 32'h00000013);
    chk("t1_state", 64'(state_o), 64'd1);
    chk("t1_instr", instr_cnt_o, 64'd10);
    chk("t1_hang", 64'(hang_o), 64'd0);
    chk("t1_done", 64'(done_o), 64'd0);
    do_reset();
    stall_limit_i = 20;
    en_i = 1'b1;
    cyc("t2_enter", 5'b00000, '0, '0);
    cyc("t2_ret", 5'b11100, 39'h2000, 32'h00000013);
    for (int k = 1; k <= 25; k++) begin
      cyc("t2_idle", 5'b00000, '0, '0);
      chk("t2_hang_edge", 64'(hang_o), 64'(k >= 20));
      chk("t2_state_edge", 64'(state_o), (k >= 20) ? 64'd3 : 64'd1);
    end
    do_reset();
    stall_limit_i = 0;
    en_i = 1'b1;
    for (int k = 0; k < 1000; k++) cyc("t2_nolimit", 5'b00000, '0, '0);
    chk("t2_nolimit_state", 64'(state_o), 64'd1);
    do_reset();
    en_i = 1'b1;
    cyc("t3_enter", 5'b00000, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc("t3_spin", 5'b11100, loop_pc, jal_self);
      chk("t3_done_edge", 64'(done_o), 64'(i == 3));
    end
    chk("t3_state", 64'(state_o), 64'd2);
    do_reset();
    en_i = 1'b1;
    cyc("t3b_enter", 5'b00000, '0, '0);
    for (int i = 0; i < 3; i++) cyc("t3b_spin", 5'b11100, loop_pc, jal_self);
    cyc("t3b_trap", 5'b11010, loop_pc, jal_self);
    chk("t3b_after_trap", 64'(done_o), 64'd0);
    for (int i = 0; i < 4; i++) cyc("t3b_spin2", 5'b11100, loop_pc, jal_self);
    chk("t3b_done", 64'(done_o), 64'd1);
    chk("t3b_state", 64'(state_o), 64'd2);
    do_reset();
    stall_limit_i = 30;
    en_i = 1'b1;
    for (int k = 0; k < 51; k++) cyc("t4_bp", 5'b10100, 39'h3000, 32'h00000013);
    chk("t4_state", 64'(state_o), 64'd3);
    chk("t4_hang", 64'(hang_o), 64'd1);
    chk("t4_instr", instr_cnt_o, 64'd0);
    do_reset();
    stall_limit_i = 0;
    en_i = 1'b1;
    cyc("t5_enter", 5'b00000, '0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc("t5_dbg", 5'b11101, 39'h4000 + 39'(8 * i), 32'h00000013);
      cyc("t5_ret", 5'b11100, 39'h4004 + 39'(8 * i), 32'h00000013);
    end
    cyc("t5_trap", 5'b11010, 39'h5000, 32'h00000073);
    cyc("t5_trap", 5'b11010, 39'h5004, 32'h00000073);
    chk("t5_instr", instr_cnt_o, 64'd5);
    chk("t5_trapcnt", 64'(trap_cnt_o), 64'd2);
    freeze_i = 1'b1;
    cyc("t5_freeze", 5'b00000, '0, '0);
    chk("t5_frz_state", 64'(state_o), 64'd0);
    chk("t5_frz_instr", instr_cnt_o, 64'd0);
    chk("t5_frz_trap", 64'(trap_cnt_o), 64'd0);
    freeze_i = 1'b0;
    cyc("t5_rerun", 5'b00000, '0, '0);
    chk("t5_rerun_state", 64'(state_o), 64'd1);
    for (int r = 0; r < 8; r++) begin
      do_reset();
      stall_limit_i = sw'($urandom_range(3, 40));
      for (int k = 0; k < 250; k++) begin
        logic [vw-1:0] pcs [3];
        pcs = '{39'h80000100, 39'h80000200, 39'h00001234};
        en_i = ($urandom % 8) != 0;
        freeze_i = ($urandom % 50) == 0;
        cyc("rand", {1'($urandom), 1'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 6) == 0},
            pcs[$urandom % 3], ($urandom % 2) ? jal_self : $urandom);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
